// File: rtl/risc_pkg.sv
// Shared types and encodings for the multicycle RISC control unit.
package risc_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLL = 3'b100,
      ALU_SRL = 3'b101
   } alu_op_t;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_EXEC_MA,
      S_MEM_RD,
      S_WB_MEM,
      S_MEM_WR,
      S_WB_ALU,
      S_BRANCH,
      S_TRAP
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_WORD    = 3'b010;
   localparam logic [2:0] F3_SRL     = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_BEQ     = 3'b000;

   localparam logic       ADDR_PC     = 1'b0;
   localparam logic       ADDR_ALUOUT = 1'b1;
   localparam logic       SRCA_PC     = 1'b0;
   localparam logic       SRCA_RS1    = 1'b1;
   localparam logic [1:0] SRCB_RS2    = 2'b00;
   localparam logic [1:0] SRCB_IMM    = 2'b01;
   localparam logic       WB_ALUOUT   = 1'b0;
   localparam logic       WB_MDR      = 1'b1;
   localparam logic       PC_PLUS4    = 1'b0;
   localparam logic       PC_ALUOUT   = 1'b1;

   localparam logic [1:0] TRAP_NONE    = 2'b00;
   localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
   localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

endpackage

// File: rtl/risc_alu_dec.sv
// ALU operation decoder shared by register-register and register-immediate ops.
module risc_alu_dec
   import risc_pkg::*;
(
   input  logic       is_imm,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output alu_op_t    alu_op,
   output logic       legal
);

   // Immediate forms ignore bit 30 except on shifts, where it must be clear.
   always_comb begin
      alu_op = ALU_ADD;
      legal  = 1'b0;
      case (funct3)
         F3_ADD_SUB: begin
            if (is_imm || !funct7_5) begin
               alu_op = ALU_ADD;
               legal  = 1'b1;
            end else begin
               alu_op = ALU_SUB;
               legal  = 1'b1;
            end
         end
         F3_AND: begin
            alu_op = ALU_AND;
            legal  = is_imm || !funct7_5;
         end
         F3_OR: begin
            alu_op = ALU_OR;
            legal  = is_imm || !funct7_5;
         end
         F3_SLL: begin
            alu_op = ALU_SLL;
            legal  = !funct7_5;
         end
         F3_SRL: begin
            alu_op = ALU_SRL;
            legal  = !funct7_5;
         end
         default: begin
            alu_op = ALU_ADD;
            legal  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/risc_mc_ctrl.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback with memory
// handshake, optional request timeout and sticky trap reporting.
module risc_mc_ctrl
   import risc_pkg::*;
#(
   parameter int MEM_TIMEOUT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_we,
   output logic       mdr_we,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic       aluout_we,
   output logic       rf_we,
   output logic       wb_sel,
   output logic       pc_we,
   output logic       pc_sel,
   output logic       instr_done,
   output logic       trap,
   output logic [1:0] trap_cause
);

   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TIMEOUT_LIMIT = CW'(MEM_TIMEOUT);

   state_t        state_q, state_d;
   logic          trap_q, trap_d;
   logic [1:0]    trap_cause_q, trap_cause_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic [CW-1:0] wait_inc;
   logic          timeout_hit;

   alu_op_t       dec_op;
   logic          dec_legal;
   logic          dec_is_imm;

   assign dec_is_imm  = (state_q == S_EXEC_I);
   assign wait_inc    = wait_cnt_q + CW'(1);
   assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_inc == TIMEOUT_LIMIT);

   risc_alu_dec u_alu_dec (
      .is_imm   (dec_is_imm),
      .funct3   (funct3),
      .funct7_5 (funct7_5),
      .alu_op   (dec_op),
      .legal    (dec_legal)
   );

   // State, sticky trap and wait counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_FETCH;
         trap_q       <= 1'b0;
         trap_cause_q <= TRAP_NONE;
         wait_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         trap_q       <= trap_d;
         trap_cause_q <= trap_cause_d;
         wait_cnt_q   <= wait_cnt_d;
      end
   end

   // Next-state and control outputs; everything is forced low while in reset.
   always_comb begin
      state_d      = state_q;
      trap_d       = trap_q;
      trap_cause_d = trap_cause_q;
      wait_cnt_d   = wait_cnt_q;

      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = ADDR_PC;
      ir_we      = 1'b0;
      mdr_we     = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      alu_op     = ALU_ADD;
      aluout_we  = 1'b0;
      rf_we      = 1'b0;
      wb_sel     = WB_ALUOUT;
      pc_we      = 1'b0;
      pc_sel     = PC_PLUS4;
      instr_done = 1'b0;
      trap       = trap_q;
      trap_cause = trap_cause_q;

      case (state_q)
         S_FETCH: begin
            mem_req  = 1'b1;
            addr_sel = ADDR_PC;
            if (mem_ready) begin
               ir_we      = 1'b1;
               wait_cnt_d = '0;
               state_d    = S_DECODE;
            end else if (timeout_hit) begin
               wait_cnt_d   = '0;
               trap_d       = 1'b1;
               trap_cause_d = TRAP_TIMEOUT;
               state_d      = S_TRAP;
            end else begin
               wait_cnt_d = wait_inc;
            end
         end
         S_DECODE: begin
            alu_src_a = SRCA_PC;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_ADD;
            aluout_we = 1'b1;
            case (opcode)
               OP_R:              state_d = S_EXEC_R;
               OP_I:              state_d = S_EXEC_I;
               OP_LOAD, OP_STORE: state_d = S_EXEC_MA;
               OP_BRANCH:         state_d = S_BRANCH;
               default: begin
                  trap_d       = 1'b1;
                  trap_cause_d = TRAP_ILLEGAL;
                  state_d      = S_TRAP;
               end
            endcase
         end
         S_EXEC_R, S_EXEC_I: begin
            if (dec_legal) begin
               alu_src_a = SRCA_RS1;
               alu_src_b = (state_q == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
               alu_op    = dec_op;
               aluout_we = 1'b1;
               state_d   = S_WB_ALU;
            end else begin
               trap_d       = 1'b1;
               trap_cause_d = TRAP_ILLEGAL;
               state_d      = S_TRAP;
            end
         end
         S_WB_ALU: begin
            rf_we      = 1'b1;
            wb_sel     = WB_ALUOUT;
            pc_we      = 1'b1;
            pc_sel     = PC_PLUS4;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_EXEC_MA: begin
            if (funct3 == F3_WORD) begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_IMM;
               alu_op    = ALU_ADD;
               aluout_we = 1'b1;
               state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end else begin
               trap_d       = 1'b1;
               trap_cause_d = TRAP_ILLEGAL;
               state_d      = S_TRAP;
            end
         end
         S_MEM_RD, S_MEM_WR: begin
            mem_req  = 1'b1;
            mem_we   = (state_q == S_MEM_WR);
            addr_sel = ADDR_ALUOUT;
            if (mem_ready) begin
               wait_cnt_d = '0;
               if (state_q == S_MEM_RD) begin
                  mdr_we  = 1'b1;
                  state_d = S_WB_MEM;
               end else begin
                  pc_we      = 1'b1;
                  pc_sel     = PC_PLUS4;
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end
            end else if (timeout_hit) begin
               wait_cnt_d   = '0;
               trap_d       = 1'b1;
               trap_cause_d = TRAP_TIMEOUT;
               state_d      = S_TRAP;
            end else begin
               wait_cnt_d = wait_inc;
            end
         end
         S_WB_MEM: begin
            rf_we      = 1'b1;
            wb_sel     = WB_MDR;
            pc_we      = 1'b1;
            pc_sel     = PC_PLUS4;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            if (funct3 == F3_BEQ) begin
               alu_src_a  = SRCA_RS1;
               alu_src_b  = SRCB_RS2;
               alu_op     = ALU_SUB;
               pc_we      = 1'b1;
               pc_sel     = zero ? PC_ALUOUT : PC_PLUS4;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else begin
               trap_d       = 1'b1;
               trap_cause_d = TRAP_ILLEGAL;
               state_d      = S_TRAP;
            end
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      if (rst) begin
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         addr_sel   = 1'b0;
         ir_we      = 1'b0;
         mdr_we     = 1'b0;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'b00;
         alu_op     = 3'b000;
         aluout_we  = 1'b0;
         rf_we      = 1'b0;
         wb_sel     = 1'b0;
         pc_we      = 1'b0;
         pc_sel     = 1'b0;
         instr_done = 1'b0;
         trap       = 1'b0;
         trap_cause = 2'b00;
      end
   end

endmodule

// File: tb/tb_risc_mc_ctrl.sv
// Directed testbench for the multicycle control unit (timeout set to 8 cycles).
module tb_risc_mc_ctrl;

   logic       clk;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, mem_we, addr_sel, ir_we, mdr_we, alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op;
   logic       aluout_we, rf_we, wb_sel, pc_we, pc_sel, instr_done, trap;
   logic [1:0] trap_cause;
   logic [19:0] obs;

   int errors = 0;
   int checks = 0;

   localparam logic [19:0] MREQ     = 20'h1 << 19;
   localparam logic [19:0] MWE      = 20'h1 << 18;
   localparam logic [19:0] ASEL     = 20'h1 << 17;
   localparam logic [19:0] IRWE     = 20'h1 << 16;
   localparam logic [19:0] MDRWE    = 20'h1 << 15;
   localparam logic [19:0] SRCA     = 20'h1 << 14;
   localparam logic [19:0] SRCB_IMM = 20'h1 << 12;
   localparam logic [19:0] ALUOUT   = 20'h1 << 8;
   localparam logic [19:0] RFWE     = 20'h1 << 7;
   localparam logic [19:0] WBSEL    = 20'h1 << 6;
   localparam logic [19:0] PCWE     = 20'h1 << 5;
   localparam logic [19:0] PCSEL    = 20'h1 << 4;
   localparam logic [19:0] DONE     = 20'h1 << 3;
   localparam logic [19:0] TRAPF    = 20'h1 << 2;
   localparam logic [19:0] C_ILL    = 20'h1;
   localparam logic [19:0] C_TO     = 20'h2;

   risc_mc_ctrl #(.MEM_TIMEOUT(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct3     (funct3),
      .funct7_5   (funct7_5),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .addr_sel   (addr_sel),
      .ir_we      (ir_we),
      .mdr_we     (mdr_we),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .aluout_we  (aluout_we),
      .rf_we      (rf_we),
      .wb_sel     (wb_sel),
      .pc_we      (pc_we),
      .pc_sel     (pc_sel),
      .instr_done (instr_done),
      .trap       (trap),
      .trap_cause (trap_cause)
   );

   assign obs = {mem_req, mem_we, addr_sel, ir_we, mdr_we, alu_src_a, alu_src_b,
                 alu_op, aluout_we, rf_we, wb_sel, pc_we, pc_sel, instr_done,
                 trap, trap_cause};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [19:0] opf(input logic [2:0] op);
      return {8'h00, op, 9'h000};
   endfunction

   task automatic applyStimulus(input logic rdy, input logic z);
      mem_ready = rdy;
      zero      = z;
   endtask

   task automatic checkOutput(input string tag, input logic [19:0] expected);
      checks++;
      assert (obs === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%05h expected=%05h", tag, obs, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input logic rdy, input logic z,
                       input logic [19:0] expected);
      applyStimulus(rdy, z);
      #1;
      checkOutput(tag, expected);
      tick();
   endtask

   task automatic setInstr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      opcode   = op;
      funct3   = f3;
      funct7_5 = f7;
   endtask

   task automatic runArith(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [2:0] aop);
      logic [19:0] srcb;
      srcb = (op == 7'b0010011) ? SRCB_IMM : 20'h0;
      setInstr(op, f3, f7);
      step({tag, ".fetch"},  1'b1, 1'b0, MREQ | IRWE);
      step({tag, ".decode"}, 1'b1, 1'b0, SRCB_IMM | ALUOUT);
      step({tag, ".exec"},   1'b1, 1'b1, SRCA | srcb | opf(aop) | ALUOUT);
      step({tag, ".wb"},     1'b1, 1'b0, RFWE | PCWE | DONE);
   endtask

   initial begin
      rst = 1'b1;
      setInstr(7'b0110011, 3'b000, 1'b0);
      applyStimulus(1'b1, 1'b1);
      tick();
      checkOutput("reset.outputs_zero", 20'h0);
      tick();
      checkOutput("reset.hold", 20'h0);
      rst = 1'b0;

      runArith("r.add", 7'b0110011, 3'b000, 1'b0, 3'b000);
      runArith("r.sub", 7'b0110011, 3'b000, 1'b1, 3'b001);
      runArith("r.and", 7'b0110011, 3'b111, 1'b0, 3'b010);
      runArith("r.or",  7'b0110011, 3'b110, 1'b0, 3'b011);
      runArith("r.sll", 7'b0110011, 3'b001, 1'b0, 3'b100);
      runArith("r.srl", 7'b0110011, 3'b101, 1'b0, 3'b101);
      runArith("i.addi_b30", 7'b0010011, 3'b000, 1'b1, 3'b000);
      runArith("i.andi", 7'b0010011, 3'b111, 1'b0, 3'b010);
      runArith("i.ori",  7'b0010011, 3'b110, 1'b1, 3'b011);
      runArith("i.slli", 7'b0010011, 3'b001, 1'b0, 3'b100);
      runArith("i.srli", 7'b0010011, 3'b101, 1'b0, 3'b101);

      setInstr(7'b0000011, 3'b010, 1'b0);
      step("lw.fetch",   1'b1, 1'b0, MREQ | IRWE);
      step("lw.decode",  1'b1, 1'b0, SRCB_IMM | ALUOUT);
      step("lw.exec",    1'b1, 1'b0, SRCA | SRCB_IMM | ALUOUT);
      step("lw.wait1",   1'b0, 1'b0, MREQ | ASEL);
      step("lw.wait2",   1'b0, 1'b0, MREQ | ASEL);
      step("lw.wait3",   1'b0, 1'b0, MREQ | ASEL);
      step("lw.ready",   1'b1, 1'b0, MREQ | ASEL | MDRWE);
      step("lw.wb",      1'b1, 1'b0, RFWE | WBSEL | PCWE | DONE);

      setInstr(7'b1100011, 3'b000, 1'b0);
      step("beq_t.fetch",  1'b1, 1'b0, MREQ | IRWE);
      step("beq_t.decode", 1'b1, 1'b0, SRCB_IMM | ALUOUT);
      step("beq_t.branch", 1'b1, 1'b1, SRCA | opf(3'b001) | PCWE | PCSEL | DONE);
      step("beq_n.fetch",  1'b1, 1'b1, MREQ | IRWE);
      step("beq_n.decode", 1'b1, 1'b1, SRCB_IMM | ALUOUT);
      step("beq_n.branch", 1'b1, 1'b0, SRCA | opf(3'b001) | PCWE | DONE);

      setInstr(7'b0100011, 3'b010, 1'b0);
      step("sw.fetch_wait", 1'b0, 1'b0, MREQ);
      step("sw.fetch",      1'b1, 1'b0, MREQ | IRWE);
      step("sw.decode",     1'b1, 1'b0, SRCB_IMM | ALUOUT);
      step("sw.exec",       1'b1, 1'b0, SRCA | SRCB_IMM | ALUOUT);
      step("sw.wait1",      1'b0, 1'b0, MREQ | MWE | ASEL);
      applyStimulus(1'b0, 1'b0);
      #1;
      checkOutput("sw.wait2_before_rst", MREQ | MWE | ASEL);
      rst = 1'b1;
      #1;
      checkOutput("rst.mid_write", 20'h0);
      tick();
      checkOutput("rst.after_sample", 20'h0);
      tick();
      rst = 1'b0;
      step("rst.refetch_wait", 1'b0, 1'b0, MREQ);
      step("sw2.fetch",        1'b1, 1'b0, MREQ | IRWE);
      step("sw2.decode",       1'b1, 1'b0, SRCB_IMM | ALUOUT);
      step("sw2.exec",         1'b1, 1'b0, SRCA | SRCB_IMM | ALUOUT);
      step("sw2.ready",        1'b1, 1'b0, MREQ | MWE | ASEL | PCWE | DONE);

      setInstr(7'b0110011, 3'b101, 1'b1);
      step("ill_r.fetch",  1'b1, 1'b0, MREQ | IRWE);
      step("ill_r.decode", 1'b1, 1'b0, SRCB_IMM | ALUOUT);
      step("ill_r.exec",   1'b1, 1'b0, 20'h0);
      step("ill_r.trap",   1'b1, 1'b0, TRAPF | C_ILL);
      step("ill_r.sticky", 1'b1, 1'b1, TRAPF | C_ILL);

      rst = 1'b1;
      tick();
      checkOutput("rst.clear_trap", 20'h0);
      rst = 1'b0;

      setInstr(7'b1111111, 3'b000, 1'b0);
      step("ill_op.fetch",  1'b1, 1'b0, MREQ | IRWE);
      step("ill_op.decode", 1'b1, 1'b0, SRCB_IMM | ALUOUT);
      step("ill_op.trap",   1'b1, 1'b0, TRAPF | C_ILL);

      rst = 1'b1;
      tick();
      rst = 1'b0;
      setInstr(7'b0110011, 3'b000, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step($sformatf("to.wait%0d", i + 1), 1'b0, 1'b0, MREQ);
      end
      step("to.trap",   1'b0, 1'b0, TRAPF | C_TO);
      step("to.sticky", 1'b1, 1'b0, TRAPF | C_TO);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
